// File: rtl/pipe_stage_skid_if.sv
// Handshake, payload and status signals of one elastic pipeline stage.
// The slave side is the stage itself; the master side is the surrounding pipeline.
interface pipe_stage_skid_if #(
    parameter int unsigned DATA_W = 51,
    parameter int unsigned CTRL_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;

    modport master (
        output in_valid, in_data, in_ctrl, flush, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, occupancy
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, flush, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, occupancy
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with flush-to-bubble and an optional
// two-entry skid buffer that keeps in_ready free of any out_ready path.
module pipe_stage_skid #(
    parameter int unsigned       DATA_W      = 51,
    parameter int unsigned       CTRL_W      = 5,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = 5'b10000,
    parameter bit                SKID        = 1'b1
) (
    input logic              clk,
    input logic              rst,
    pipe_stage_skid_if.slave bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stateE;

    typedef enum logic [1:0] {
        MAIN_HOLD,
        MAIN_FROM_IN,
        MAIN_FROM_SKID,
        MAIN_BUBBLE
    } mainSelE;

    stateE             state, nextState;
    mainSelE           mainSel;
    logic              loadSkid;
    logic              bubbleSkid;
    logic              inReadyQ;
    logic [DATA_W-1:0] mainData, skidData;
    logic [CTRL_W-1:0] mainCtrl, skidCtrl;
    logic              outValid;
    logic              accept;
    logic              drain;

    assign outValid = (state != EMPTY);
    assign accept   = bus.in_valid & bus.in_ready;
    assign drain    = outValid & bus.out_ready;

    // NOTE: every output of this block gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        nextState  = state;
        mainSel    = MAIN_HOLD;
        loadSkid   = 1'b0;
        bubbleSkid = 1'b0;
        if (bus.flush) begin
            nextState  = EMPTY;
            mainSel    = MAIN_BUBBLE;
            bubbleSkid = 1'b1;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        nextState = ONE;
                        mainSel   = MAIN_FROM_IN;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        mainSel = MAIN_FROM_IN;
                    end else if (accept) begin
                        // Only reachable with the skid buffer; without it in_ready implies drain.
                        nextState = FULL;
                        loadSkid  = 1'b1;
                    end else if (drain) begin
                        nextState = EMPTY;
                        mainSel   = MAIN_BUBBLE;
                    end
                end
                FULL: begin
                    if (drain) begin
                        nextState = ONE;
                        mainSel   = MAIN_FROM_SKID;
                    end
                end
                default: begin
                    nextState = EMPTY;
                    mainSel   = MAIN_BUBBLE;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= EMPTY;
            inReadyQ <= 1'b1;
            // NOTE: payload registers are reset too, because out_data=0 and out_ctrl=bubble are visible right after reset.
            mainData <= '0;
            mainCtrl <= CTRL_BUBBLE;
            skidData <= '0;
            skidCtrl <= CTRL_BUBBLE;
        end else begin
            state    <= nextState;
            inReadyQ <= (nextState != FULL);

            unique case (mainSel)
                MAIN_FROM_IN: begin
                    mainData <= bus.in_data;
                    mainCtrl <= bus.in_ctrl;
                end
                MAIN_FROM_SKID: begin
                    mainData <= skidData;
                    mainCtrl <= skidCtrl;
                end
                MAIN_BUBBLE: mainCtrl <= CTRL_BUBBLE;
                default: ;
            endcase

            if (bubbleSkid) begin
                skidCtrl <= CTRL_BUBBLE;
            end else if (loadSkid) begin
                skidData <= bus.in_data;
                skidCtrl <= bus.in_ctrl;
            end
        end
    end

    // Registered ready breaks the out_ready -> in_ready path; the single-entry form trades that for less storage.
    generate
        if (SKID) begin : g_skid
            assign bus.in_ready = inReadyQ;
        end else begin : g_noskid
            assign bus.in_ready = ~outValid | bus.out_ready;
        end
    endgenerate

    assign bus.out_valid = outValid;
    assign bus.out_data  = mainData;
    assign bus.out_ctrl  = mainCtrl;
    assign bus.occupancy = {SKID & state[1], state[0]};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: one skid instance and one single-entry
// instance, with per-instance scoreboards checked by negedge monitors.
module tb_pipe_stage_skid;

    localparam logic [4:0] BUBBLE = 5'b10000;

    typedef struct packed {
        logic [50:0] data;
        logic [4:0]  ctrl;
    } entryT;

    logic  clk;
    logic  rst;
    int    nChecks = 0;
    int    nErrors = 0;
    entryT q1[$];
    entryT q0[$];
    entryT exp1, exp0;

    pipe_stage_skid_if #(.DATA_W(51), .CTRL_W(5)) bus1 ();
    pipe_stage_skid_if #(.DATA_W(51), .CTRL_W(5)) bus0 ();

    pipe_stage_skid #(.DATA_W(51), .CTRL_W(5), .CTRL_BUBBLE(BUBBLE), .SKID(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    pipe_stage_skid #(.DATA_W(51), .CTRL_W(5), .CTRL_BUBBLE(BUBBLE), .SKID(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        nChecks++;
        if (act !== req) begin
            nErrors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input bit v, input logic [50:0] d, input logic [4:0] c, input bit push);
        bus1.in_valid = v;
        bus1.in_data  = d;
        bus1.in_ctrl  = c;
        if (push) q1.push_back({d, c});
    endtask

    task automatic drive0(input bit v, input logic [50:0] d, input logic [4:0] c, input bit push);
        bus0.in_valid = v;
        bus0.in_data  = d;
        bus0.in_ctrl  = c;
        if (push) q0.push_back({d, c});
    endtask

    // Monitors: a drain (out_valid & out_ready before the edge) pops the scoreboard.
    always @(negedge clk) begin
        if (bus1.out_valid && bus1.out_ready) begin
            if (q1.size() == 0) begin
                nChecks++;
                nErrors++;
                $display("FAIL sb1_extra: got out_data=%0h, expected no output", bus1.out_data);
            end else begin
                exp1 = q1.pop_front();
                check("sb1_data", 64'(bus1.out_data), 64'(exp1.data));
                check("sb1_ctrl", 64'(bus1.out_ctrl), 64'(exp1.ctrl));
            end
        end
        if (!bus1.out_valid) check("sb1_bubble", 64'(bus1.out_ctrl), 64'(BUBBLE));
    end

    always @(negedge clk) begin
        if (bus0.out_valid && bus0.out_ready) begin
            if (q0.size() == 0) begin
                nChecks++;
                nErrors++;
                $display("FAIL sb0_extra: got out_data=%0h, expected no output", bus0.out_data);
            end else begin
                exp0 = q0.pop_front();
                check("sb0_data", 64'(bus0.out_data), 64'(exp0.data));
                check("sb0_ctrl", 64'(bus0.out_ctrl), 64'(exp0.ctrl));
            end
        end
        if (!bus0.out_valid) check("sb0_bubble", 64'(bus0.out_ctrl), 64'(BUBBLE));
    end

    initial begin
        logic [4:0] c;

        rst            = 1'b1;
        bus1.flush     = 1'b0;
        bus1.out_ready = 1'b0;
        bus0.flush     = 1'b0;
        bus0.out_ready = 1'b0;
        drive1(1'b0, '0, '0, 1'b0);
        drive0(1'b0, '0, '0, 1'b0);
        #1 rst = 1'b0;
        #1;

        // Reset values
        check("rst_out_valid", 64'(bus1.out_valid), 64'd0);
        check("rst_out_data",  64'(bus1.out_data),  64'd0);
        check("rst_out_ctrl",  64'(bus1.out_ctrl),  64'(BUBBLE));
        check("rst_occupancy", 64'(bus1.occupancy), 64'd0);
        check("rst_in_ready",  64'(bus1.in_ready),  64'd1);
        check("rst0_in_ready", 64'(bus0.in_ready),  64'd1);
        #10 rst = 1'b1;

        // Streaming at full rate
        tick();
        bus1.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            c = 5'(i) | 5'b01000;
            drive1(1'b1, 51'(i), c, 1'b1);
            tick();
            check("stream_valid",    64'(bus1.out_valid), 64'd1);
            check("stream_data",     64'(bus1.out_data),  64'(i));
            check("stream_occ",      64'(bus1.occupancy), 64'd1);
            check("stream_in_ready", 64'(bus1.in_ready),  64'd1);
        end
        drive1(1'b0, '0, '0, 1'b0);
        tick();
        check("stream_end_occ", 64'(bus1.occupancy), 64'd0);

        // Backpressure fill, then ordered drain
        bus1.out_ready = 1'b0;
        drive1(1'b1, 51'h0AAA, 5'b01111, 1'b1);
        tick();
        check("fill_occ1",     64'(bus1.occupancy), 64'd1);
        check("fill_ready1",   64'(bus1.in_ready),  64'd1);
        drive1(1'b1, 51'h0BBB, 5'b00111, 1'b1);
        tick();
        check("fill_occ2",     64'(bus1.occupancy), 64'd2);
        check("fill_ready0",   64'(bus1.in_ready),  64'd0);
        check("fill_head",     64'(bus1.out_data),  64'h0AAA);
        drive1(1'b1, 51'h0CCC, 5'b00011, 1'b1);
        tick();
        check("stall_occ",     64'(bus1.occupancy), 64'd2);
        check("stall_head",    64'(bus1.out_data),  64'h0AAA);
        check("stall_ctrl",    64'(bus1.out_ctrl),  64'h0F);
        bus1.out_ready = 1'b1;
        tick();
        check("drain_head_b",  64'(bus1.out_data),  64'h0BBB);
        check("drain_occ",     64'(bus1.occupancy), 64'd1);
        check("drain_ready",   64'(bus1.in_ready),  64'd1);
        tick();
        check("drain_head_c",  64'(bus1.out_data),  64'h0CCC);
        drive1(1'b0, '0, '0, 1'b0);
        tick();
        check("drain_end_occ", 64'(bus1.occupancy), 64'd0);

        // Flush while FULL with an input offered
        bus1.out_ready = 1'b0;
        drive1(1'b1, 51'h0DDD, 5'b00001, 1'b0);
        tick();
        drive1(1'b1, 51'h0EEE, 5'b00010, 1'b0);
        tick();
        drive1(1'b1, 51'h0FFF, 5'b00100, 1'b0);
        bus1.flush = 1'b1;
        tick();
        check("flushf_valid", 64'(bus1.out_valid), 64'd0);
        check("flushf_ctrl",  64'(bus1.out_ctrl),  64'(BUBBLE));
        check("flushf_occ",   64'(bus1.occupancy), 64'd0);
        check("flushf_ready", 64'(bus1.in_ready),  64'd1);
        check("flushf_data",  64'(bus1.out_data),  64'h0DDD);
        bus1.flush = 1'b0;
        drive1(1'b0, '0, '0, 1'b0);
        bus1.out_ready = 1'b1;
        tick();
        check("flushf_after", 64'(bus1.out_valid), 64'd0);

        // Flush in ONE discards the input accepted in the same cycle
        bus1.out_ready = 1'b0;
        drive1(1'b1, 51'h0123, 5'b00110, 1'b0);
        tick();
        drive1(1'b1, 51'h0456, 5'b01010, 1'b0);
        bus1.flush = 1'b1;
        tick();
        check("flush1_occ",  64'(bus1.occupancy), 64'd0);
        check("flush1_data", 64'(bus1.out_data),  64'h0123);
        bus1.flush = 1'b0;
        drive1(1'b0, '0, '0, 1'b0);
        bus1.out_ready = 1'b1;
        tick();
        check("flush1_after", 64'(bus1.out_valid), 64'd0);

        // Flush concurrent with a drain: head still delivered
        drive1(1'b1, 51'h1234, 5'b01100, 1'b1);
        tick();
        check("flushd_head", 64'(bus1.out_data), 64'h1234);
        drive1(1'b0, '0, '0, 1'b0);
        bus1.flush = 1'b1;
        tick();
        check("flushd_occ", 64'(bus1.occupancy), 64'd0);
        bus1.flush = 1'b0;

        // Async reset mid-stall
        bus1.out_ready = 1'b0;
        drive1(1'b1, 51'h0777, 5'b00101, 1'b0);
        tick();
        drive1(1'b1, 51'h0888, 5'b01001, 1'b0);
        tick();
        check("arst_pre_occ", 64'(bus1.occupancy), 64'd2);
        drive1(1'b0, '0, '0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("arst_valid", 64'(bus1.out_valid), 64'd0);
        check("arst_data",  64'(bus1.out_data),  64'd0);
        check("arst_ctrl",  64'(bus1.out_ctrl),  64'(BUBBLE));
        check("arst_ready", 64'(bus1.in_ready),  64'd1);
        check("arst_occ",   64'(bus1.occupancy), 64'd0);
        rst = 1'b1;
        tick();

        // Single-entry instance
        drive0(1'b1, 51'h0111, 5'b00011, 1'b1);
        tick();
        check("s0_valid", 64'(bus0.out_valid), 64'd1);
        check("s0_occ",   64'(bus0.occupancy), 64'd1);
        check("s0_ready_stall", 64'(bus0.in_ready), 64'd0);
        drive0(1'b1, 51'h0222, 5'b00101, 1'b1);
        #1;
        check("s0_ready_hold", 64'(bus0.in_ready), 64'd0);
        tick();
        check("s0_head_held", 64'(bus0.out_data), 64'h0111);
        bus0.out_ready = 1'b1;
        #1;
        check("s0_ready_comb", 64'(bus0.in_ready), 64'd1);
        tick();
        check("s0_repl_m",   64'(bus0.out_data),  64'h0222);
        check("s0_occ_m",    64'(bus0.occupancy), 64'd1);
        drive0(1'b1, 51'h0333, 5'b01001, 1'b1);
        tick();
        check("s0_repl_n",   64'(bus0.out_data),  64'h0333);
        check("s0_occ_n",    64'(bus0.occupancy), 64'd1);
        drive0(1'b1, 51'h0444, 5'b01110, 1'b1);
        tick();
        check("s0_repl_p",   64'(bus0.out_data),  64'h0444);
        drive0(1'b0, '0, '0, 1'b0);
        tick();
        check("s0_end_occ",   64'(bus0.occupancy), 64'd0);
        check("s0_end_ready", 64'(bus0.in_ready),  64'd1);

        tick();
        tick();
        check("q1_drained", 64'(q1.size()), 64'd0);
        check("q0_drained", 64'(q0.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
